alu_slice_sequencer: RTL

//  Multi-cycle controller that runs one 4-bit 74181 slice over a 4*NIBBLES-bit

---
 rtl/alu_slice_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alu_slice_sequencer.sv
// Sequences one 4-bit 74181 slice across a NIBBLES*4-bit operand, one nibble per
// enabled clock edge. The order is LSB first, and carry ripples through a register.
// Latency: rsp_valid rises NIBBLES enabled edges after the accepting edge.
// Backpressure: req_ready is high only in IDLE. The result is held in DONE until
// an enabled edge sees rsp_ready. ena=0 freezes everything except rst.
// Ports: clk/rst/ena control; req_* request handshake and operands;
//        slc_* drive and observe the external alu_74181; rsp_* result handshake.
// Optional: define ALU_SEQ_PG_EN to add rsp_p/rsp_g group propagate/generate
//           outputs in 74181 active-low polarity.
module alu_slice_sequencer #(
    parameter int NIBBLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [4*NIBBLES-1:0]   req_a,
    input  logic [4*NIBBLES-1:0]   req_b,
    input  logic [3:0]             req_s,
    input  logic                   req_m,
    input  logic                   req_cn,
    output logic [3:0]             slc_a,
    output logic [3:0]             slc_b,
    output logic [3:0]             slc_s,
    output logic                   slc_m,
    output logic                   slc_cn,
    input  logic [3:0]             slc_f,
    input  logic                   slc_cn4,
    input  logic                   slc_equal,
    input  logic                   slc_p,
    input  logic                   slc_g,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [4*NIBBLES-1:0]   rsp_f,
    output logic                   rsp_cout,
`ifdef ALU_SEQ_PG_EN
    output logic                   rsp_p,
    output logic                   rsp_g,
`endif
    output logic                   rsp_equal
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic [IW-1:0]             idx_q;
    logic [NIBBLES-1:0][3:0]   a_q;
    logic [NIBBLES-1:0][3:0]   b_q;
    logic [NIBBLES-1:0][3:0]   f_q;
    logic [3:0]                s_q;
    logic                      m_q;
    logic                      carry_q;
    logic                      eq_acc;
    logic                      last_nib;
    logic                      accept;
    logic [IW-1:0]             nib_sel;
`ifdef ALU_SEQ_PG_EN
    logic                      p_acc;
    logic                      g_acc;
`endif

    assign last_nib = (idx_q == IW'(NIBBLES - 1));
    assign accept   = ena && req_valid && (state_q == IDLE);

    // Outside RUN the slice sees nibble 0 of the captured operands, so it never sees X.
    assign nib_sel = (state_q == RUN) ? idx_q : '0;
    assign slc_a   = a_q[nib_sel];
    assign slc_b   = b_q[nib_sel];
    assign slc_s   = s_q;
    assign slc_m   = m_q;
    assign slc_cn  = carry_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_f     = '0;
        rsp_cout  = 1'b0;
        rsp_equal = 1'b0;
`ifdef ALU_SEQ_PG_EN
        rsp_p     = 1'b0;
        rsp_g     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = RUN;
            end
            RUN: begin
                if (last_nib) state_d = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                rsp_f     = f_q;
                rsp_cout  = carry_q;
                rsp_equal = eq_acc;
`ifdef ALU_SEQ_PG_EN
                rsp_p     = p_acc;
                rsp_g     = g_acc;
`endif
                // Returning to IDLE here means a request can only be taken on a later edge.
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            carry_q <= 1'b0;
            eq_acc  <= 1'b1;
`ifdef ALU_SEQ_PG_EN
            p_acc   <= 1'b0;
            g_acc   <= 1'b1;
`endif
        end else if (accept) begin
            a_q     <= req_a;
            b_q     <= req_b;
            s_q     <= req_s;
            m_q     <= req_m;
            carry_q <= req_cn;
            eq_acc  <= 1'b1;
            idx_q   <= '0;
`ifdef ALU_SEQ_PG_EN
            p_acc   <= 1'b0;
            g_acc   <= 1'b1;
`endif
        end else if (ena && state_q == RUN) begin
            f_q[idx_q] <= slc_f;
            carry_q    <= slc_cn4;
            eq_acc     <= eq_acc & slc_equal;
            if (!last_nib) idx_q <= idx_q + 1'b1;
`ifdef ALU_SEQ_PG_EN
            // Active-low lookahead combine: the group propagates only if every nibble
            // propagates. It generates if the upper nibble generates, or if the upper
            // nibble propagates a generate from below.
            p_acc <= p_acc | slc_p;
            g_acc <= slc_g & (slc_p | g_acc);
`endif
        end
    end

endmodule
